// File: rtl/spi_0_fabric_slave.sv
// Fabric-side SPI mode-0 responder for the MSS SPI_0 link. SPI pins are oversampled
// in the fabric clock domain; TX words come through a one-deep holding register.
module spi_0_fabric_slave #(
  parameter int                  DATA_WIDTH  = 8,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD = DATA_WIDTH'(8'hFF)
) (
  input  logic                  FAB_CCC_GL0,
  input  logic                  FAB_RESET_N,
  input  logic                  SPI_SCLK,
  input  logic                  SPI_SS_N,
  input  logic                  SPI_MOSI,
  output logic                  SPI_MISO,
  output logic                  SPI_MISO_OE,
  input  logic [DATA_WIDTH-1:0] TX_DATA,
  input  logic                  TX_VALID,
  output logic                  TX_READY,
  output logic [DATA_WIDTH-1:0] RX_DATA,
  output logic                  RX_VALID,
  output logic                  TX_UNDERRUN,
  output logic                  BUSY
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t                  r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0]  r_sclk_sync, r_ss_sync, r_mosi_sync;
  logic                    r_sclk_d, r_ss_d;
  logic [DATA_WIDTH-1:0]   r_hold;
  logic                    r_hold_valid;
  logic [DATA_WIDTH-1:0]   r_tx_shift;
  logic [DATA_WIDTH-2:0]   r_rx_shift;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic                    r_word_done;
  logic [DATA_WIDTH-1:0]   r_rx_data;
  logic                    r_rx_valid, r_underrun, r_miso, r_busy;

  logic w_sclk, w_ss_n, w_mosi;
  logic w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;
  logic w_load, w_tx_shl, w_rx_sample, w_abort, w_accept, w_last_bit;
  logic [DATA_WIDTH-1:0] w_rx_word;

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss_n = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_ss_fall   = ~w_ss_n & r_ss_d;
  assign w_ss_rise   = w_ss_n & ~r_ss_d;

  assign w_accept   = TX_VALID & ~r_hold_valid;
  assign w_last_bit = (r_bit_cnt == LAST_BIT);
  assign w_rx_word  = {r_rx_shift, w_mosi};

  // NOTE: SS_N resets high so a reset release never looks like a select edge.
  always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_ss_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SPI_SCLK};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SPI_SS_N};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
      r_sclk_d    <= w_sclk;
      r_ss_d      <= w_ss_n;
    end
  end

  always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) r_state <= S_IDLE;
    else              r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_tx_shl    = 1'b0;
    w_rx_sample = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ss_fall) begin
          w_state_nxt = S_SHIFT;
          w_load      = 1'b1;
        end
      end
      S_SHIFT: begin
        // Deselect wins over any SCLK strobe landing in the same cycle.
        if (w_ss_rise) begin
          w_state_nxt = S_IDLE;
          w_abort     = 1'b1;
        end else if (w_sclk_rise) begin
          w_rx_sample = 1'b1;
        end else if (w_sclk_fall) begin
          if (r_word_done) w_load   = 1'b1;
          else             w_tx_shl = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_tx_shift   <= '0;
      r_rx_shift   <= '0;
      r_bit_cnt    <= '0;
      r_word_done  <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_underrun   <= 1'b0;
      r_miso       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;

      // A same-cycle load sees the register empty; the accepted word waits for the next load.
      if (w_accept) begin
        r_hold       <= TX_DATA;
        r_hold_valid <= 1'b1;
      end else if (w_load) begin
        r_hold_valid <= 1'b0;
      end

      if (w_load) begin
        r_tx_shift  <= r_hold_valid ? r_hold : IDLE_WORD;
        r_underrun  <= ~r_hold_valid;
        r_word_done <= 1'b0;
        if (r_state == S_IDLE) r_bit_cnt <= '0;
      end else if (w_tx_shl) begin
        r_tx_shift <= r_tx_shift << 1;
      end

      if (w_rx_sample) begin
        r_rx_shift <= w_rx_word[DATA_WIDTH-2:0];
        if (w_last_bit) begin
          r_rx_data   <= w_rx_word;
          r_rx_valid  <= 1'b1;
          r_bit_cnt   <= '0;
          r_word_done <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end

      if (w_abort) begin
        r_bit_cnt   <= '0;
        r_word_done <= 1'b0;
      end

      r_miso <= (r_state == S_SHIFT) & r_tx_shift[DATA_WIDTH-1];
      r_busy <= (r_state == S_SHIFT);
    end
  end

  assign SPI_MISO    = r_miso;
  assign SPI_MISO_OE = r_busy;
  assign BUSY        = r_busy;
  assign TX_READY    = ~r_hold_valid;
  assign RX_DATA     = r_rx_data;
  assign RX_VALID    = r_rx_valid;
  assign TX_UNDERRUN = r_underrun;

endmodule

// File: tb/tb_spi_0_fabric_slave.sv
// Bench for spi_0_fabric_slave: an SPI mode-0 master model plus an RX scoreboard
// fed with expected words as frames are launched.
module tb_spi_0_fabric_slave;

  localparam int W    = 8;
  localparam int HALF = 4;

  logic         clk = 1'b0;
  logic         FAB_RESET_N = 1'b0;
  logic         SPI_SCLK = 1'b0;
  logic         SPI_SS_N = 1'b1;
  logic         SPI_MOSI = 1'b0;
  logic         SPI_MISO, SPI_MISO_OE;
  logic [W-1:0] TX_DATA = '0;
  logic         TX_VALID = 1'b0;
  logic         TX_READY;
  logic [W-1:0] RX_DATA;
  logic         RX_VALID, TX_UNDERRUN, BUSY;

  int n_cmp = 0;
  int n_bad = 0;
  int n_rxv = 0;
  int n_und = 0;

  logic [W-1:0] rx_exp[$];
  logic [W-1:0] m_tx[3];
  logic [W-1:0] m_rx[3];

  spi_0_fabric_slave #(.DATA_WIDTH(W), .SYNC_STAGES(2), .IDLE_WORD(8'hFF)) dut (
    .FAB_CCC_GL0 (clk),
    .FAB_RESET_N (FAB_RESET_N),
    .SPI_SCLK    (SPI_SCLK),
    .SPI_SS_N    (SPI_SS_N),
    .SPI_MOSI    (SPI_MOSI),
    .SPI_MISO    (SPI_MISO),
    .SPI_MISO_OE (SPI_MISO_OE),
    .TX_DATA     (TX_DATA),
    .TX_VALID    (TX_VALID),
    .TX_READY    (TX_READY),
    .RX_DATA     (RX_DATA),
    .RX_VALID    (RX_VALID),
    .TX_UNDERRUN (TX_UNDERRUN),
    .BUSY        (BUSY)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard side: every RX_VALID pulse pops one expected word.
  always @(negedge clk) begin
    if (FAB_RESET_N) begin
      if (RX_VALID) begin
        logic [W-1:0] e;
        n_rxv++;
        n_cmp++;
        if (rx_exp.size() == 0) begin
          n_bad++;
          $display("FAIL rx_unexpected: got %h, none expected", RX_DATA);
        end else begin
          e = rx_exp.pop_front();
          if (RX_DATA !== e) begin
            n_bad++;
            $display("FAIL rx_word: got %h, expected %h", RX_DATA, e);
          end
        end
      end
      if (TX_UNDERRUN) n_und++;
    end
  end

  task automatic load_tx(input logic [W-1:0] d);
    int t = 0;
    @(negedge clk);
    while (!TX_READY && t < 400) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (TX_READY !== 1'b1) begin
      n_bad++;
      $display("FAIL tx_ready_timeout: TX_READY=%b, expected 1", TX_READY);
    end else begin
      TX_DATA  = d;
      TX_VALID = 1'b1;
      @(negedge clk);
      TX_VALID = 1'b0;
    end
  endtask

  // Mode-0 master; ends with SCLK low and SS_N high in the same instant.
  task automatic master_frame(input int nw, input int stop_rises, input bit rst_abort);
    int total = nw * W;
    @(negedge clk);
    SPI_SS_N = 1'b0;
    SPI_MOSI = m_tx[0][W-1];
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < total; i++) begin
      SPI_SCLK = 1'b1;
      m_rx[i / W][W - 1 - (i % W)] = SPI_MISO;
      repeat (HALF) @(negedge clk);
      if (i == total - 1 || i + 1 == stop_rises) begin
        if (rst_abort) begin
          n_cmp++;
          if (SPI_MISO_OE !== 1'b1) begin
            n_bad++;
            $display("FAIL oe_before_reset: got %b, expected 1", SPI_MISO_OE);
          end
          FAB_RESET_N = 1'b0;
          #1;
          n_cmp++;
          if (SPI_MISO_OE !== 1'b0 || SPI_MISO !== 1'b0) begin
            n_bad++;
            $display("FAIL oe_async_reset: oe=%b miso=%b, expected 0 0", SPI_MISO_OE, SPI_MISO);
          end
        end
        SPI_SCLK = 1'b0;
        SPI_SS_N = 1'b1;
        break;
      end
      SPI_SCLK = 1'b0;
      SPI_MOSI = m_tx[(i + 1) / W][W - 1 - ((i + 1) % W)];
      repeat (HALF) @(negedge clk);
    end
    if (rst_abort) begin
      repeat (3) @(negedge clk);
      FAB_RESET_N = 1'b1;
    end
    repeat (4 * HALF) @(negedge clk);
  endtask

  task automatic check_rx_drained(input string tag);
    n_cmp++;
    if (rx_exp.size() != 0) begin
      n_bad++;
      $display("FAIL %s_rx_missing: %0d words pending, expected 0", tag, rx_exp.size());
    end
  endtask

  task automatic test_reset();
    repeat (6) @(negedge clk) SPI_SCLK = ~SPI_SCLK;
    n_cmp++;
    if (SPI_MISO_OE !== 1'b0 || RX_VALID !== 1'b0 || TX_READY !== 1'b1 ||
        RX_DATA !== 8'h00 || BUSY !== 1'b0 || SPI_MISO !== 1'b0 || TX_UNDERRUN !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_values: oe=%b rxv=%b rdy=%b rx=%h busy=%b miso=%b und=%b, expected 0 0 1 00 0 0 0",
               SPI_MISO_OE, RX_VALID, TX_READY, RX_DATA, BUSY, SPI_MISO, TX_UNDERRUN);
    end
    FAB_RESET_N = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (n_rxv != 0 || n_und != 0 || BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: rx_pulses=%0d underruns=%0d busy=%b, expected 0 0 0", n_rxv, n_und, BUSY);
    end
  endtask

  task automatic test_single_word();
    int rxv0 = n_rxv;
    int und0 = n_und;
    load_tx(8'hA5);
    @(negedge clk);
    n_cmp++;
    if (TX_READY !== 1'b0) begin
      n_bad++;
      $display("FAIL single_ready_held: got %b, expected 0", TX_READY);
    end
    m_tx[0] = 8'h3C;
    rx_exp.push_back(8'h3C);
    master_frame(1, 0, 1'b0);
    n_cmp++;
    if (m_rx[0] !== 8'hA5) begin
      n_bad++;
      $display("FAIL single_miso: got %h, expected a5", m_rx[0]);
    end
    n_cmp++;
    if (n_rxv - rxv0 != 1 || RX_DATA !== 8'h3C) begin
      n_bad++;
      $display("FAIL single_rx: pulses=%0d data=%h, expected 1 3c", n_rxv - rxv0, RX_DATA);
    end
    n_cmp++;
    if (TX_READY !== 1'b1 || n_und - und0 != 0) begin
      n_bad++;
      $display("FAIL single_ready_underrun: rdy=%b underruns=%0d, expected 1 0", TX_READY, n_und - und0);
    end
    check_rx_drained("single");
  endtask

  task automatic test_back_to_back();
    int rxv0, und0;
    load_tx(8'hA5);
    rxv0 = n_rxv;
    und0 = n_und;
    m_tx[0] = 8'h11; m_tx[1] = 8'h22; m_tx[2] = 8'h33;
    rx_exp.push_back(8'h11); rx_exp.push_back(8'h22); rx_exp.push_back(8'h33);
    fork
      master_frame(3, 0, 1'b0);
      begin
        load_tx(8'h44);
        load_tx(8'h55);
      end
    join
    n_cmp++;
    if (m_rx[0] !== 8'hA5 || m_rx[1] !== 8'h44 || m_rx[2] !== 8'h55) begin
      n_bad++;
      $display("FAIL b2b_miso: got %h %h %h, expected a5 44 55", m_rx[0], m_rx[1], m_rx[2]);
    end
    n_cmp++;
    if (n_rxv - rxv0 != 3 || n_und - und0 != 0) begin
      n_bad++;
      $display("FAIL b2b_counts: rx_pulses=%0d underruns=%0d, expected 3 0", n_rxv - rxv0, n_und - und0);
    end
    check_rx_drained("b2b");
  endtask

  task automatic test_underrun();
    int und0 = n_und;
    m_tx[0] = 8'h00;
    rx_exp.push_back(8'h00);
    master_frame(1, 0, 1'b0);
    n_cmp++;
    if (m_rx[0] !== 8'hFF) begin
      n_bad++;
      $display("FAIL underrun_miso: got %h, expected ff", m_rx[0]);
    end
    n_cmp++;
    if (n_und - und0 != 1 || RX_DATA !== 8'h00) begin
      n_bad++;
      $display("FAIL underrun_pulse: underruns=%0d rx=%h, expected 1 00", n_und - und0, RX_DATA);
    end
    check_rx_drained("underrun");
  endtask

  task automatic test_abort();
    int rxv0 = n_rxv;
    int und0;
    m_tx[0] = 8'hE7;
    fork
      master_frame(1, 5, 1'b0);
      begin
        repeat (8) @(negedge clk);
        load_tx(8'h96);
      end
    join
    n_cmp++;
    if (n_rxv - rxv0 != 0 || RX_DATA !== 8'h00 || TX_READY !== 1'b0 || BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_state: pulses=%0d rx=%h rdy=%b busy=%b, expected 0 00 0 0",
               n_rxv - rxv0, RX_DATA, TX_READY, BUSY);
    end
    und0 = n_und;
    m_tx[0] = 8'hC7;
    rx_exp.push_back(8'hC7);
    master_frame(1, 0, 1'b0);
    n_cmp++;
    if (m_rx[0] !== 8'h96 || RX_DATA !== 8'hC7 || n_und - und0 != 0) begin
      n_bad++;
      $display("FAIL abort_next_frame: miso=%h rx=%h underruns=%0d, expected 96 c7 0",
               m_rx[0], RX_DATA, n_und - und0);
    end
    check_rx_drained("abort");
  endtask

  task automatic test_reset_mid_frame();
    int und0;
    load_tx(8'h3E);
    m_tx[0] = 8'hAA;
    fork
      master_frame(1, 3, 1'b1);
      begin
        repeat (8) @(negedge clk);
        load_tx(8'h77);
      end
    join
    n_cmp++;
    if (TX_READY !== 1'b1 || RX_DATA !== 8'h00 || BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_after: rdy=%b rx=%h busy=%b, expected 1 00 0", TX_READY, RX_DATA, BUSY);
    end
    und0 = n_und;
    m_tx[0] = 8'h5A;
    rx_exp.push_back(8'h5A);
    master_frame(1, 0, 1'b0);
    n_cmp++;
    if (m_rx[0] !== 8'hFF || RX_DATA !== 8'h5A || n_und - und0 != 1) begin
      n_bad++;
      $display("FAIL rstmid_next_frame: miso=%h rx=%h underruns=%0d, expected ff 5a 1",
               m_rx[0], RX_DATA, n_und - und0);
    end
    check_rx_drained("rstmid");
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
